// File: rtl/frame_freeze_scheduler.sv
// Aligns frame_buffer freeze/resume transitions to OV7670 frame boundaries, with a camera watchdog.
// Optional auto-resume after a hold time: define FRAME_FREEZE_AUTO_RESUME_EN.
module frame_freeze_scheduler #(
  parameter int TIMEOUT_CYC = 4000000,
  parameter int CNT_W       = 16,
  parameter int HOLD_CYC    = 300000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ov7670_v_sync,
  input  logic             freeze_req,
  input  logic             resume_req,
  output logic             frame_stop,
  output logic             frozen,
  output logic             busy,
  output logic             req_ack,
  output logic             cam_timeout,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    LIVE       = 2'd0,
    ARM_FREEZE = 2'd1,
    FROZEN     = 2'd2,
    ARM_RESUME = 2'd3
  } state_t;

  state_t          state;
  logic            s1, s2, s3;
  logic            vs_edge;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_fire;
  logic            resume_int;

  // Rising vsync marks the end of the active frame: the only safe switch point.
  assign vs_edge = s2 & ~s3;
  assign wd_fire = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign frozen  = frame_stop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= ov7670_v_sync;
      s2 <= s1;
      s3 <= s2;
    end
  end

`ifdef FRAME_FREEZE_AUTO_RESUME_EN
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_active;
  logic              enter_frozen;

  assign enter_frozen = ((state == ARM_FREEZE) && (vs_edge || wd_fire)) ||
                        ((state == ARM_RESUME) && !(vs_edge || wd_fire) && freeze_req);
  assign resume_int   = resume_req | (hold_active && (hold_cnt == '0));

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_active <= 1'b0;
      hold_cnt    <= '0;
    end else if (enter_frozen) begin
      hold_active <= 1'b1;
      hold_cnt    <= HOLD_W'(HOLD_CYC - 1);
    end else if ((state != FROZEN) || resume_req) begin
      hold_active <= 1'b0;
    end else if (hold_active && (hold_cnt != '0)) begin
      hold_cnt <= hold_cnt - 1'b1;
    end else begin
      hold_active <= 1'b0;
    end
  end
`else
  assign resume_int = resume_req;
`endif

  // Handshake: requests are single-cycle pulses with no ready; a request is
  // accepted only in LIVE/FROZEN and every completion or cancel pulses req_ack once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= LIVE;
      frame_stop  <= 1'b0;
      busy        <= 1'b0;
      req_ack     <= 1'b0;
      cam_timeout <= 1'b0;
      frame_cnt   <= '0;
      wd_cnt      <= '0;
    end else begin
      req_ack <= 1'b0;
      case (state)
        LIVE: begin
          wd_cnt <= '0;
          if (vs_edge) frame_cnt <= frame_cnt + 1'b1;
          if (freeze_req && !resume_req) begin
            state <= ARM_FREEZE;
            busy  <= 1'b1;
          end
        end
        ARM_FREEZE: begin
          wd_cnt <= vs_edge ? '0 : wd_cnt + 1'b1;
          if (vs_edge || wd_fire) begin
            state       <= FROZEN;
            frame_stop  <= 1'b1;
            busy        <= 1'b0;
            req_ack     <= 1'b1;
            cam_timeout <= !vs_edge;
            if (vs_edge) frame_cnt <= frame_cnt + 1'b1;
          end else if (resume_req) begin
            state   <= LIVE;
            busy    <= 1'b0;
            req_ack <= 1'b1;
          end
        end
        FROZEN: begin
          wd_cnt <= '0;
          if (resume_int && !freeze_req) begin
            state <= ARM_RESUME;
            busy  <= 1'b1;
          end
        end
        ARM_RESUME: begin
          wd_cnt <= vs_edge ? '0 : wd_cnt + 1'b1;
          if (vs_edge || wd_fire) begin
            state       <= LIVE;
            frame_stop  <= 1'b0;
            busy        <= 1'b0;
            req_ack     <= 1'b1;
            cam_timeout <= !vs_edge;
          end else if (freeze_req) begin
            state   <= FROZEN;
            busy    <= 1'b0;
            req_ack <= 1'b1;
          end
        end
        default: state <= LIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_freeze_scheduler.sv
// Directed bench for frame_freeze_scheduler; expected output words queue up as stimulus is driven.
module tb_frame_freeze_scheduler;

  localparam int CNT_W = 16;
  localparam int W     = 5 + CNT_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             ov7670_v_sync = 1'b0;
  logic             freeze_req = 1'b0;
  logic             resume_req = 1'b0;
  logic             frame_stop, frozen, busy, req_ack, cam_timeout;
  logic [CNT_W-1:0] frame_cnt;

  logic [W-1:0] exp_q[$];
  int           pass_cnt = 0;
  int           chk_cnt  = 0;
  int           ack_cnt  = 0;
  int           ack_saved;

  frame_freeze_scheduler #(
    .TIMEOUT_CYC(100),
    .CNT_W      (CNT_W),
    .HOLD_CYC   (50)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ov7670_v_sync(ov7670_v_sync),
    .freeze_req   (freeze_req),
    .resume_req   (resume_req),
    .frame_stop   (frame_stop),
    .frozen       (frozen),
    .busy         (busy),
    .req_ack      (req_ack),
    .cam_timeout  (cam_timeout),
    .frame_cnt    (frame_cnt)
  );

  // clock
  always #5 clk = ~clk;

  always @(negedge clk) if (req_ack) ack_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic fs, input logic bsy, input logic ack,
                          input logic ct, input int cnt);
    exp_q.push_back({fs, fs, bsy, ack, ct, CNT_W'(cnt)});
  endtask

  task automatic check(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    obs = {frame_stop, frozen, busy, req_ack, cam_timeout, frame_cnt};
    chk_cnt++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed stop/frz/busy/ack/ct/cnt=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_acks(input string tag, input int expected);
    chk_cnt++;
    assert (ack_cnt === expected) pass_cnt++;
    else $error("FAIL %s: observed ack count %0d expected %0d", tag, ack_cnt, expected);
  endtask

  task automatic pulse_freeze();
    freeze_req = 1'b1;
    tick(1);
    freeze_req = 1'b0;
  endtask

  task automatic pulse_resume();
    resume_req = 1'b1;
    tick(1);
    resume_req = 1'b0;
  endtask

  task automatic frame();
    ov7670_v_sync = 1'b1;
    tick(4);
    ov7670_v_sync = 1'b0;
    tick(20);
  endtask

  initial begin
    tick(3);
    exp_push(0, 0, 0, 0, 0);
    check("reset");
    reset = 1'b1;
    tick(2);
    ack_cnt = 0;

    for (int i = 0; i < 5; i++) frame();
    exp_push(0, 0, 0, 0, 5);
    check("count5");
    check_acks("no_ack_live", 0);

`ifndef FRAME_FREEZE_AUTO_RESUME_EN
    // freeze lands exactly two edges after vsync is first sampled high
    tick(7);
    exp_push(0, 1, 0, 0, 5);
    pulse_freeze();
    check("arm_busy");
    exp_push(0, 1, 0, 0, 5);
    tick(10);
    check("arm_wait");
    ov7670_v_sync = 1'b1;
    exp_push(0, 1, 0, 0, 5);
    tick(2);
    check("pre_edge");
    exp_push(1, 0, 1, 0, 6);
    tick(1);
    check("freeze_done");
    exp_push(1, 0, 0, 0, 6);
    tick(1);
    check("ack_drop");
    ov7670_v_sync = 1'b0;
    tick(20);

    for (int i = 0; i < 3; i++) frame();
    exp_push(1, 0, 0, 0, 6);
    check("frozen_hold");
    exp_push(1, 1, 0, 0, 6);
    pulse_resume();
    check("arm_resume");
    tick(5);
    ov7670_v_sync = 1'b1;
    exp_push(1, 1, 0, 0, 6);
    tick(2);
    check("resume_pre_edge");
    exp_push(0, 0, 1, 0, 6);
    tick(1);
    check("resume_done");
    tick(1);
    ov7670_v_sync = 1'b0;
    tick(20);
    frame();
    exp_push(0, 0, 0, 0, 7);
    check("count_after_resume");

    // cancel of a pending freeze with no camera edge
    pulse_freeze();
    tick(9);
    exp_push(0, 0, 1, 0, 7);
    pulse_resume();
    check("cancel_freeze");
    exp_push(0, 0, 0, 0, 7);
    tick(1);
    check("cancel_ack_drop");

    // cancel arriving with the frame edge loses
    pulse_freeze();
    ov7670_v_sync = 1'b1;
    tick(2);
    exp_push(1, 0, 1, 0, 8);
    resume_req = 1'b1;
    tick(1);
    resume_req = 1'b0;
    check("edge_beats_cancel");
    tick(1);
    ov7670_v_sync = 1'b0;
    tick(20);

    exp_push(1, 0, 0, 0, 8);
    freeze_req = 1'b1;
    resume_req = 1'b1;
    tick(1);
    freeze_req = 1'b0;
    resume_req = 1'b0;
    check("both_ignored");

    pulse_resume();
    tick(5);
    exp_push(1, 0, 1, 0, 8);
    pulse_freeze();
    check("cancel_resume");

    pulse_resume();
    frame();
    exp_push(0, 0, 0, 0, 8);
    check("back_live");

    // watchdog: freeze sampled at edge 0 is forced at edge 100
    pulse_freeze();
    exp_push(0, 1, 0, 0, 8);
    tick(99);
    check("wd_pre");
    exp_push(1, 0, 1, 1, 8);
    tick(1);
    check("wd_fire");
    exp_push(1, 1, 0, 1, 8);
    pulse_resume();
    check("arm_resume_ct");
    ov7670_v_sync = 1'b1;
    exp_push(0, 0, 1, 0, 8);
    tick(3);
    check("resume_clears_ct");
    tick(1);
    ov7670_v_sync = 1'b0;
    tick(20);

    // reset in the middle of a pending resume
    pulse_freeze();
    frame();
    exp_push(1, 0, 0, 0, 9);
    check("refrozen");
    pulse_resume();
    tick(3);
    ack_saved = ack_cnt;
    reset = 1'b0;
    exp_push(0, 0, 0, 0, 0);
    tick(1);
    check("reset_mid_arm");
    reset = 1'b1;
    tick(3);
    check_acks("no_ack_on_reset", ack_saved);
`else
    // auto-resume: ARM_RESUME entered 50 cycles after FROZEN entry
    pulse_freeze();
    ov7670_v_sync = 1'b1;
    exp_push(1, 0, 1, 0, 6);
    tick(3);
    check("auto_frozen");
    ov7670_v_sync = 1'b0;
    exp_push(1, 0, 0, 0, 6);
    tick(49);
    check("auto_wait");
    exp_push(1, 1, 0, 0, 6);
    tick(1);
    check("auto_arm");
    ov7670_v_sync = 1'b1;
    exp_push(0, 0, 1, 0, 6);
    tick(3);
    check("auto_live");
    tick(1);
    ov7670_v_sync = 1'b0;
    tick(20);

    pulse_freeze();
    frame();
    tick(30);
    ack_saved = ack_cnt;
    exp_push(1, 1, 0, 0, 7);
    check("auto_arm2");
    reset = 1'b0;
    exp_push(0, 0, 0, 0, 0);
    tick(1);
    check("reset_mid_arm");
    reset = 1'b1;
    tick(3);
    check_acks("no_ack_on_reset", ack_saved);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
